// File: rtl/rpm_ctrl_pkg.sv
// Shared types and helpers for the multi-motor RPM mixer/controller.
// Clamp helpers work on 32-bit signed values so they serve any RPM word width up to 30 bits.
package rpm_ctrl_pkg;

    localparam int RPM_W_DEF = 16;

    typedef logic        [RPM_W_DEF-1:0] rpm_t;
    typedef logic signed [RPM_W_DEF-1:0] trim_t;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        SPINUP   = 2'd1,
        ARMED    = 2'd2,
        FAILSAFE = 2'd3
    } state_e;

    function automatic int clamp_rpm(input logic signed [31:0] mixed, input int lo, input int hi);
        int result;
        result = mixed;
        if (mixed < lo) begin
            result = lo;
        end else if (mixed > hi) begin
            result = hi;
        end
        return result;
    endfunction

    function automatic logic is_clamped(input logic signed [31:0] mixed, input int lo, input int hi);
        return (mixed < lo) || (mixed > hi);
    endfunction

endpackage

// File: rtl/rpm_slew_limiter.sv
// One motor channel: holds the target and the slew-limited rpm_set register.
// rpm_set always chases the target value held before this edge, giving one cycle of load latency.
module rpm_slew_limiter #(
    parameter int RPM_W     = 16,
    parameter int SLEW_STEP = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_load,
    input  logic [RPM_W-1:0] tgt_value,
    input  logic             zero_out,
    output logic [RPM_W-1:0] target,
    output logic [RPM_W-1:0] rpm_set
);

    localparam logic [RPM_W-1:0] STEP = RPM_W'(SLEW_STEP);

    logic [RPM_W-1:0] target_reg;
    logic [RPM_W-1:0] rpm_reg;
    logic [RPM_W-1:0] rpm_next;

    // Differences are taken in the direction that cannot underflow.
    always_comb begin
        rpm_next = target_reg;
        if (target_reg > rpm_reg) begin
            if ((target_reg - rpm_reg) > STEP) begin
                rpm_next = rpm_reg + STEP;
            end
        end else if ((rpm_reg - target_reg) > STEP) begin
            rpm_next = rpm_reg - STEP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_reg <= '0;
            rpm_reg    <= '0;
        end else begin
            if (tgt_load) begin
                target_reg <= tgt_value;
            end
            rpm_reg <= zero_out ? '0 : rpm_next;
        end
    end

    assign target  = target_reg;
    assign rpm_set = rpm_reg;

endmodule

// File: rtl/rpm_mixer_ctrl.sv
// Multi-motor RPM set-point controller: base + per-motor trim mixing with clamping,
// per-channel slew limiting, and an arming FSM with a command-timeout failsafe.
module rpm_mixer_ctrl
    import rpm_ctrl_pkg::*;
#(
    parameter int NUM_MOTORS  = 4,
    parameter int RPM_W       = 16,
    parameter int SLEW_STEP   = 64,
    parameter int RPM_MIN     = 1000,
    parameter int RPM_MAX     = 12000,
    parameter int IDLE_RPM    = 1500,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        arm,
    input  logic                        disarm,
    input  logic                        cmd_valid,
    input  logic [RPM_W-1:0]            base_rpm,
    input  logic [NUM_MOTORS*RPM_W-1:0] dir_trim,
    output logic [NUM_MOTORS*RPM_W-1:0] rpm_set,
    output logic [NUM_MOTORS-1:0]       sat,
    output logic [1:0]                  state,
    output logic                        fault,
    output logic                        at_target
);

    localparam int               CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [RPM_W-1:0] IDLE_V = RPM_W'(IDLE_RPM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                fault_reg;
    logic [NUM_MOTORS-1:0] sat_reg;

    logic [NUM_MOTORS-1:0] mix_sat;
    logic [NUM_MOTORS-1:0] ch_idle;
    logic [NUM_MOTORS-1:0] ch_zero;
    logic [NUM_MOTORS-1:0] ch_match;

    logic tgt_load;
    logic tgt_sel_idle;
    logic tgt_sel_mix;
    logic zero_out;
    logic timeout;

    assign timeout  = (state_reg == ARMED) && (cnt_reg == CNT_LAST);
    assign zero_out = disarm || (state_reg == DISARMED);

    // Target source per edge; priority disarm > timeout > cmd_valid > arm.
    always_comb begin
        tgt_load     = 1'b0;
        tgt_sel_idle = 1'b0;
        tgt_sel_mix  = 1'b0;
        if (disarm) begin
            tgt_load = 1'b1;
        end else begin
            case (state_reg)
                DISARMED: begin
                    tgt_load     = 1'b1;
                    tgt_sel_idle = arm;
                end
                ARMED: begin
                    if (timeout) begin
                        tgt_load = 1'b1;
                    end else if (cmd_valid) begin
                        tgt_load    = 1'b1;
                        tgt_sel_mix = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_MOTORS; gi++) begin : g_ch
            logic signed [RPM_W+1:0] sum;
            logic signed [31:0]      sum_ext;
            logic [RPM_W-1:0]        mix_value;
            logic [RPM_W-1:0]        tgt_value;
            logic [RPM_W-1:0]        target_ch;
            logic [RPM_W-1:0]        rpm_ch;

            // Two guard bits keep base + trim from wrapping before the clamp.
            assign sum = $signed({2'b00, base_rpm})
                       + $signed({{2{dir_trim[gi*RPM_W+RPM_W-1]}}, dir_trim[gi*RPM_W +: RPM_W]});
            assign sum_ext     = 32'(sum);
            assign mix_value   = RPM_W'(clamp_rpm(sum_ext, RPM_MIN, RPM_MAX));
            assign mix_sat[gi] = is_clamped(sum_ext, RPM_MIN, RPM_MAX);

            assign tgt_value = tgt_sel_mix  ? mix_value :
                               tgt_sel_idle ? IDLE_V    : '0;

            rpm_slew_limiter #(
                .RPM_W     (RPM_W),
                .SLEW_STEP (SLEW_STEP)
            ) u_slew (
                .clk       (clk),
                .reset     (reset),
                .tgt_load  (tgt_load),
                .tgt_value (tgt_value),
                .zero_out  (zero_out),
                .target    (target_ch),
                .rpm_set   (rpm_ch)
            );

            assign rpm_set[gi*RPM_W +: RPM_W] = rpm_ch;
            assign ch_idle[gi]  = (rpm_ch == IDLE_V);
            assign ch_zero[gi]  = (rpm_ch == '0);
            assign ch_match[gi] = (rpm_ch == target_ch);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= DISARMED;
            cnt_reg   <= '0;
            fault_reg <= 1'b0;
            sat_reg   <= '0;
        end else if (disarm) begin
            state_reg <= DISARMED;
            cnt_reg   <= '0;
            sat_reg   <= '0;
        end else begin
            case (state_reg)
                DISARMED: begin
                    cnt_reg <= '0;
                    if (arm) begin
                        state_reg <= SPINUP;
                        fault_reg <= 1'b0;
                    end
                end
                SPINUP: begin
                    cnt_reg <= '0;
                    if (&ch_idle) begin
                        state_reg <= ARMED;
                    end
                end
                ARMED: begin
                    if (timeout) begin
                        state_reg <= FAILSAFE;
                        fault_reg <= 1'b1;
                        cnt_reg   <= '0;
                    end else if (cmd_valid) begin
                        cnt_reg <= '0;
                        sat_reg <= mix_sat;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                FAILSAFE: begin
                    cnt_reg <= '0;
                    if (&ch_zero) begin
                        state_reg <= DISARMED;
                    end
                end
                default: begin
                    state_reg <= DISARMED;
                end
            endcase
        end
    end

    assign state     = state_reg;
    assign sat       = sat_reg;
    assign fault     = fault_reg;
    assign at_target = &ch_match;

endmodule

// File: doc/rpm_mixer_ctrl.md
Name: rpm_mixer_ctrl

Overview:
Parametrised multi-motor RPM set-point controller for the drone motor path; successor to the single-channel direction/altitude rpm combiner. It takes one base (altitude) RPM plus a signed per-motor direction trim, then mixes and clamps each channel. Each output ramps toward its target under a per-cycle slew limit. An arming state machine with command-timeout failsafe gates all outputs.

Parameters:
NUM_MOTORS, 4, number of motor channels
RPM_W, 16, RPM word width (base/set unsigned, trim signed)
SLEW_STEP, 64, max per-cycle change of any rpm_set channel
RPM_MIN, 1000, lower clamp of mixed target while ARMED
RPM_MAX, 12000, upper clamp of mixed target
IDLE_RPM, 1500, spin-up / armed-idle target
TIMEOUT_CYC, 1000, cycles without cmd_valid in ARMED before failsafe

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
arm  in  1  request arming (level, sampled per cycle)
disarm  in  1  immediate kill request
cmd_valid  in  1  base_rpm/dir_trim valid this cycle
base_rpm  in  RPM_W  unsigned altitude RPM
dir_trim  in  NUM_MOTORS*RPM_W  packed signed per-motor trim, motor m at [m*RPM_W +: RPM_W]
rpm_set  out  NUM_MOTORS*RPM_W  packed unsigned per-motor RPM command, registered
sat  out  NUM_MOTORS  target of motor m was clamped at last capture
state  out  2  0 DISARMED, 1 SPINUP, 2 ARMED, 3 FAILSAFE
fault  out  1  sticky: failsafe occurred; cleared on entry to SPINUP
at_target  out  1  all channels equal their targets

Behaviour:
- Reset (async): state=DISARMED, rpm_set=0, targets=0, sat=0, fault=0, timeout counter=0; at_target=1.
- Mixing: target_m = base_rpm + sign-extended trim_m, computed in RPM_W+2 signed bits. Clamp to [RPM_MIN, RPM_MAX]. sat[m]=1 iff clamped. Captured only in ARMED on cmd_valid; otherwise targets hold.
- Slew: each edge, per channel, d=target-rpm_set. If |d|<=SLEW_STEP, rpm_set=target; else rpm_set moves SLEW_STEP toward target. Exception: DISARMED forces rpm_set=0 immediately (no slew).
- Latency: cmd sampled at edge k updates target at k; rpm_set first moves at edge k+1.
- DISARMED: targets=0. arm=1 moves to SPINUP; targets=IDLE_RPM for all channels.
- SPINUP: ramp to IDLE_RPM. Moves to ARMED on the edge after all rpm_set==IDLE_RPM. cmd_valid is ignored.
- ARMED: cmd_valid captures targets and clears the counter. Otherwise the counter increments. When the counter reaches TIMEOUT_CYC-1 with no cmd_valid, the next edge moves to FAILSAFE; fault=1 and all targets=0.
- FAILSAFE: ramp down to 0, ignoring cmd_valid and arm. Moves to DISARMED on the edge after all rpm_set==0.
- disarm=1 in any state: next edge DISARMED, rpm_set=0, targets=0, sat=0. fault is retained.
- Priority on the same edge: disarm > timeout > cmd_valid > arm.
- arm held high in DISARMED re-arms every time. reset mid-ramp aborts everything to reset values.
- No wrap: mixed arithmetic never wraps; negative sums clamp to RPM_MIN.

Decomposition:
- Package rpm_ctrl_pkg: state enum (DISARMED, SPINUP, ARMED, FAILSAFE), rpm_t/trim_t typedefs, and a clamp function.
- Sub-module rpm_slew_limiter: one channel, holding target and rpm_set registers with load/force-zero controls. Instantiated NUM_MOTORS times under a single FSM/timeout block.

Test Plan:
- Spin-up: reset, then arm at edge 0. Required: state=SPINUP, rpm_set rises 64,128,…,1472, then 1500 on edge 24; state=ARMED after edge 25.
- Mix: ARMED; cmd base=3000, trim={+16,-16,0,+5}. Required: targets 3016/2984/3000/3005, sat=0; channels slew 64/cycle from 1500 and settle within 24 cycles; at_target=1.
- Clamp: base=12000, trim0=+500 gives motor0 target 12000, sat[0]=1. base=500, trim1=-800 gives motor1 target 1000, sat[1]=1.
- Timeout: ARMED at 3000, no cmd_valid for 1000 cycles. Required: FAILSAFE, fault=1, ramp 64/cycle to 0, then DISARMED; arm during FAILSAFE is ignored.
- Kill: ARMED at 8000 with disarm and cmd_valid on the same edge. Required: next cycle state=DISARMED, rpm_set=0 all channels, sat=0.
- Async reset: assert reset mid-SPINUP between edges. Required: rpm_set=0 and state=DISARMED immediately, without waiting for clk.
